// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher UART output stage.
package cipher_pkg;

  // Transmitter FSM states, in frame order.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  // Line levels and frame geometry for 8N1.
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  // 100 MHz system clock at 115200 baud.
  localparam int   CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from it.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Writes while full and reads while empty are ignored.
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Pointer and count bookkeeping; simultaneous push and pop keep the count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the memory is deliberately left out of reset; empty/full come from
  // the reset count, so stale contents are never observed, and a reset-free
  // array maps onto plain RAM/LUTRAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/cipher_uart_tx.sv
// Buffers encrypted bytes and sends them as 8N1 UART frames; flags the end
// of a message once its last-tagged byte has fully left the pin.
module cipher_uart_tx
  import cipher_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t       r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_last;
  logic              r_tx;
  logic              r_tx_done;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [8:0]        w_fifo_data;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_stop_end;

  assign w_push     = din_valid && !w_full;
  assign w_bit_end  = (r_baud == BAUD_MAX);
  assign w_stop_end = (r_state == ST_STOP) && w_bit_end;
  // Pop from idle, or straight out of a finishing stop bit for gapless frames.
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_stop_end);

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (din_valid),
    .i_wr_data ({din_last, din}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign din_ready = !w_full;
  assign fifo_full = w_full;
  assign tx        = r_tx;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);
  assign overflow  = r_overflow;
  assign tx_done   = r_tx_done;

  // Frame sequencer: baud counter, bit index, shift register and the tx line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_last    <= 1'b0;
      r_tx      <= UART_STOP_BIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= UART_STOP_BIT;
          if (w_pop) begin
            r_shift <= w_fifo_data[7:0];
            r_last  <= w_fifo_data[8];
            r_baud  <= '0;
            r_tx    <= UART_START_BIT;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == LAST_BIT) begin
              r_tx    <= UART_STOP_BIT;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_data[7:0];
              r_last  <= w_fifo_data[8];
              r_tx    <= UART_START_BIT;
              r_state <= ST_START;
            end else begin
              r_tx    <= UART_STOP_BIT;
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= UART_STOP_BIT;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Message-complete flag: a new accepted byte starts a new message and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_done <= 1'b0;
    end else if (w_push) begin
      r_tx_done <= 1'b0;
    end else if (w_stop_end && r_last) begin
      r_tx_done <= 1'b1;
    end
  end

  // Sticky drop indicator for bytes offered while the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (din_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Self-checking bench for cipher_uart_tx: directed scenarios plus randomized
// traffic, all compared against a frame-timeline reference model.
module tb_cipher_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic       tx_done;

  cipher_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted bytes and the start edge of the
  // frame on the wire; the line level follows from elapsed time in the frame.
  typedef struct {
    logic [7:0] data;
    logic       last;
  } entry_t;

  entry_t m_q[$];
  entry_t m_cur;
  int     m_n      = 0;
  int     m_fstart = 0;
  bit     m_active = 0;
  bit     m_done   = 0;
  bit     m_ovf    = 0;

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_done   = 0;
    m_ovf    = 0;
  endtask

  task automatic model_edge();
    bit full_pre;
    entry_t e;
    m_n++;
    full_pre = (m_q.size() == DEPTH);
    if (m_active && (m_n - m_fstart == 10 * CPB)) begin
      if (m_cur.last) m_done = 1;
      m_active = 0;
    end
    if (!m_active && m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_fstart = m_n;
    end
    if (din_valid) begin
      if (full_pre) begin
        m_ovf = 1;
      end else begin
        e.data = din;
        e.last = din_last;
        m_q.push_back(e);
        m_done = 0;
      end
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (m_n - m_fstart) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur.data[k-1];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    check("tx",        tx,        exp_tx());
    check("din_ready", din_ready, m_q.size() != DEPTH);
    check("fifo_full", fifo_full, m_q.size() == DEPTH);
    check("busy",      busy,      m_active || (m_q.size() > 0));
    check("overflow",  overflow,  m_ovf);
    check("tx_done",   tx_done,   m_done);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check after.
  task automatic step(input logic v, input logic [7:0] d, input logic l);
    din_valid = v;
    din       = d;
    din_last  = l;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din       = 8'h00;
    din_last  = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  logic [9:0] frame;

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    din_last  = 1'b0;
    @(negedge clk);

    // Reset idle.
    do_reset();
    idle(50);

    // Single byte, last-tagged.
    step(1'b1, 8'h57, 1'b1);
    frame = '0;
    for (int i = 1; i <= 41; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (i <= 40 && ((i - 1) % CPB) == 0) frame[(i-1)/CPB] = tx;
      if (i == 40) check("done_e40", tx_done, 1'b0);
      if (i == 41) check("done_e41", tx_done, 1'b1);
      if (i == 41) check("busy_e41", busy, 1'b0);
    end
    check("sb_frame", frame, {1'b1, 8'h57, 1'b0});
    idle(5);

    // Back-to-back frames.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b1);
    idle(85);

    // tx_done clears on the next accepted push.
    step(1'b1, 8'h3C, 1'b1);
    idle(45);
    check("done_set", tx_done, 1'b1);
    step(1'b1, 8'h11, 1'b0);
    check("done_clr", tx_done, 1'b0);
    idle(45);

    // Overflow: 18 consecutive pushes, byte 17 is dropped with its last tag.
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(i), (i == 17));
      if (i == 15) check("ovf_full15", fifo_full, 1'b0);
      if (i == 16) check("ovf_full16", fifo_full, 1'b1);
      if (i == 16) check("ovf_flag16", overflow, 1'b0);
      if (i == 17) check("ovf_flag17", overflow, 1'b1);
    end
    idle(17 * 10 * CPB + 20);
    check("ovf_no_done", tx_done, 1'b0);

    // Reset during data bit 3.
    step(1'b1, 8'h00, 1'b0);
    idle(18);
    rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle(60);
    check("rst_busy", busy, 1'b0);

    // Randomized traffic at several offered loads.
    for (int p = 0; p < 4; p++) begin
      int pct;
      pct = (p == 0) ? 5 : (p == 1) ? 25 : (p == 2) ? 60 : 100;
      for (int i = 0; i < 700; i++) begin
        step($urandom_range(99, 0) < pct, 8'($urandom), $urandom_range(7, 0) == 0);
      end
    end
    idle(DEPTH * 10 * CPB + 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
